// File: rtl/cmd_seq_pkg.sv
// Shared types for the command sequencer: FSM state codes, error codes
// and the default acknowledge byte.
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_SENT = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_DONE      = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_TMO  = 2'b01,
        ERR_NACK = 2'b10
    } err_code_e;

    localparam logic [7:0] ACK_DEFAULT = 8'hA5;

endpackage

// File: rtl/cmd_sequencer_if.sv
// Host-side handshake between the sequencer and RemoteComm.
interface cmd_sequencer_if #(
    parameter int CMD_W = 16
) ();

    logic             send_cmd;
    logic [CMD_W-1:0] cmd;
    logic             cmd_sent;
    logic             resp_rdy;
    logic [7:0]       resp;

    modport master (
        output send_cmd,
        output cmd,
        input  cmd_sent,
        input  resp_rdy,
        input  resp
    );

    modport slave (
        input  send_cmd,
        input  cmd,
        output cmd_sent,
        output resp_rdy,
        output resp
    );

endinterface

// File: rtl/cmd_queue.sv
// Command storage: DEPTH x CMD_W register file filled in order, with
// an occupancy count, full flag, clear and an asynchronous read port.
module cmd_queue
    import cmd_seq_pkg::*;
#(
    parameter int CMD_W = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [CMD_W-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [CMD_W-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [CMD_W-1:0] mem [DEPTH];
    logic             wr_ok;

    assign full    = (count == CW'(DEPTH));
    assign wr_ok   = wr_en && !full && !clr && rst_n;
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wr_ok) begin
            count <= count + CW'(1);
        end
    end

    // Contents survive clr so that only count decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[count[IW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Plays a loaded queue of commands through RemoteComm, one acknowledged
// command at a time, with per-command timeout and bounded retry.
module cmd_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int         CMD_W     = 16,
    parameter int         DEPTH     = 16,
    parameter int         TMO_CYC   = 1000000,
    parameter logic [7:0] ACK       = ACK_DEFAULT,
    parameter int         MAX_RETRY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       load,
    input  logic [CMD_W-1:0]           load_cmd,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       fault,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH)-1:0]   fail_idx,
    cmd_sequencer_if.master            host
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TMO_CYC+1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY+1);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_ISSUE     = ST_ISSUE;
    localparam logic [2:0] S_WAIT_SENT = ST_WAIT_SENT;
    localparam logic [2:0] S_WAIT_RESP = ST_WAIT_RESP;
    localparam logic [2:0] S_DONE      = ST_DONE;
    localparam logic [2:0] S_FAULT     = ST_FAULT;

    localparam logic [TW-1:0] TMO_LIM   = TW'(TMO_CYC);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    logic [2:0]       state;
    logic [IW-1:0]    idx;
    logic [RW-1:0]    retry;
    logic [TW-1:0]    timer;
    logic [CMD_W-1:0] cmd_hold;
    logic [CMD_W-1:0] rd_data;
    logic             clr_ok;
    logic             load_ok;
    logic             start_ok;
    logic             last_entry;
    logic             tmo_hit;

    assign busy = (state == S_ISSUE) || (state == S_WAIT_SENT) || (state == S_WAIT_RESP);

    // clr outranks load and start; nothing is accepted mid-run.
    assign clr_ok   = clr && !busy;
    assign load_ok  = load && !busy && !clr_ok;
    assign start_ok = start && !busy && !clr_ok;

    assign last_entry = (CW'(idx) == (count - CW'(1)));
    assign tmo_hit    = (timer == TMO_LIM);

    // cmd is live from the queue during the send pulse, then held.
    assign host.send_cmd = (state == S_ISSUE);
    assign host.cmd      = (state == S_ISSUE) ? rd_data : cmd_hold;

    cmd_queue #(
        .CMD_W (CMD_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_ok),
        .wr_en   (load_ok),
        .wr_data (load_cmd),
        .rd_idx  (idx),
        .rd_data (rd_data),
        .count   (count),
        .full    (full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            retry    <= '0;
            timer    <= '0;
            cmd_hold <= '0;
            done     <= 1'b0;
            fault    <= 1'b0;
            err_code <= ERR_NONE;
            fail_idx <= '0;
        end else begin
            case (state)
                S_ISSUE: begin
                    cmd_hold <= rd_data;
                    timer    <= '0;
                    state    <= S_WAIT_SENT;
                end
                S_WAIT_SENT, S_WAIT_RESP: begin
                    if (!tmo_hit) begin
                        timer <= timer + TW'(1);
                    end
                    // A response arriving on the timeout cycle still counts.
                    if ((state == S_WAIT_RESP) && host.resp_rdy) begin
                        if (host.resp == ACK) begin
                            if (last_entry) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                idx   <= idx + IW'(1);
                                retry <= '0;
                                state <= S_ISSUE;
                            end
                        end else begin
                            state    <= S_FAULT;
                            fault    <= 1'b1;
                            err_code <= ERR_NACK;
                            fail_idx <= idx;
                        end
                    end else if (tmo_hit) begin
                        if (retry < RETRY_LIM) begin
                            retry <= retry + RW'(1);
                            state <= S_ISSUE;
                        end else begin
                            state    <= S_FAULT;
                            fault    <= 1'b1;
                            err_code <= ERR_TMO;
                            fail_idx <= idx;
                        end
                    end else if ((state == S_WAIT_SENT) && host.cmd_sent) begin
                        state <= S_WAIT_RESP;
                    end
                end
                default: begin
                    if (clr_ok) begin
                        state    <= S_IDLE;
                        done     <= 1'b0;
                        fault    <= 1'b0;
                        err_code <= ERR_NONE;
                    end else if (start_ok) begin
                        fault    <= 1'b0;
                        err_code <= ERR_NONE;
                        idx      <= '0;
                        retry    <= '0;
                        if (count == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            done  <= 1'b0;
                            state <= S_ISSUE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
Synthesizable command player that replaces hand-written bench stimulus for the Knight's Tour system. It holds a loadable queue of 16-bit commands and issues them in order through the RemoteComm host interface (send_cmd/cmd_sent/resp_rdy/resp). Each command must be acknowledged before the next is sent, with per-command timeout and bounded retry. It sits beside RemoteComm, in the bench or on an FPGA host board, and reports pass/fail status and the failing command index.

Parameters:
CMD_W, 16, command width (matches RemoteComm cmd)
DEPTH, 16, queue entries; power of 2, at least 2
TMO_CYC, 1000000, clocks allowed from send_cmd to resp_rdy before timeout
ACK, 8'hA5, response value that counts as success
MAX_RETRY, 2, re-sends allowed after a timeout (0 = no retry)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
clr  in  1  empty the queue and clear status
load  in  1  write load_cmd into the queue
load_cmd  in  CMD_W  command to enqueue
full  out  1  queue holds DEPTH entries
count  out  $clog2(DEPTH+1)  entries loaded
start  in  1  begin a run from entry 0
busy  out  1  run in progress
done  out  1  sticky; all entries ACKed
fault  out  1  sticky; run aborted
err_code  out  2  00 none, 01 timeout, 10 NACK
fail_idx  out  $clog2(DEPTH)  index of the failing entry
send_cmd  out  1  one-cycle pulse to RemoteComm
cmd  out  CMD_W  command presented to RemoteComm
cmd_sent  in  1  RemoteComm finished transmitting
resp_rdy  in  1  response byte valid (single-cycle pulse)
resp  in  8  response byte

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; count=0; busy, done, fault, send_cmd = 0; err_code=0; fail_idx=0; cmd=0. Queue contents are don't-care.
- States: IDLE, ISSUE, WAIT_SENT, WAIT_RESP, DONE, FAULT.
- Load: accepted only when not busy and count<DEPTH; it writes entry[count] and increments count. Load while full or busy is ignored without error.
- clr: accepted when not busy. It sets count=0 and clears done, fault and err_code, and returns the FSM to IDLE. clr has priority over load and start in the same cycle. clr while busy is ignored.
- start when not busy: clears done, fault and err_code. Sets idx=0 and retry=0.
  - If count=0, the FSM enters DONE next cycle with done=1.
  - Otherwise it enters ISSUE.
  - The queue is preserved, so a later start replays the same sequence.
- ISSUE (1 cycle): cmd<=entry[idx]; send_cmd=1 for exactly this cycle; timer cleared. Next state WAIT_SENT. cmd holds stable until the next ISSUE.
- WAIT_SENT: waits for cmd_sent=1, then goes to WAIT_RESP. resp_rdy in this state is ignored.
- WAIT_RESP: on resp_rdy:
  - resp==ACK: if idx==count-1, go to DONE; else idx++, retry=0, go to ISSUE. Total gap between command issues is 1 clock after resp_rdy.
  - resp!=ACK: go to FAULT with err_code=10 and fail_idx=idx. There is no retry on NACK.
- Timer: runs in WAIT_SENT and WAIT_RESP and saturates. When it reaches TMO_CYC:
  - if retry<MAX_RETRY: retry++, re-enter ISSUE (same idx, timer cleared);
  - else go to FAULT with err_code=01, fail_idx=idx.
  - If resp_rdy arrives in the same cycle the timer reaches TMO_CYC, the response wins.
- busy=1 in ISSUE, WAIT_SENT and WAIT_RESP.
- DONE and FAULT are sticky; they accept start and clr like IDLE.
- Mid-run reset: reset aborts immediately to reset values. Any send_cmd already in flight at RemoteComm is its own concern.

Decomposition:
- Package cmd_seq_pkg holds:
  - the state enum;
  - the err_code enum (ERR_NONE, ERR_TMO, ERR_NACK);
  - the default ACK constant 8'hA5.
- One sub-module, cmd_queue: DEPTH x CMD_W register file with a write pointer/count, full flag, clear, and an asynchronous read port at idx.

Test Plan:
- Load 3 cmds (16'h2502, 16'h4001, 16'h6000), start, ACK each resp 8'hA5 after cmd_sent. Expect exactly 3 send_cmd pulses with cmd values in that order. Then done=1, busy=0, fault=0.
- After the previous run, start again without loading. Expect the same 3 commands replayed and done=1.
- Load 2 cmds; reply 8'h5A to the second. Expect fault=1, err_code=10, fail_idx=1, and no further send_cmd.
- Set TMO_CYC=100, MAX_RETRY=2 and never assert resp_rdy on cmd 0. Expect 3 send_cmd pulses 101+ cycles apart, then fault=1, err_code=01, fail_idx=0.
- Load 16 entries, then a 17th load. Expect full=1 and count=16; the 17th is dropped. Then clr. Expect count=0 and full=0. Then start. Expect done=1 one cycle later with no send_cmd.
- Drop rst_n mid WAIT_RESP. Expect busy=0, send_cmd=0 and count=0 on the next posedge.
